// File: rtl/acc_arbiter.sv
// acc_arbiter: round-robin sharing of one floating-point accumulator between N requesters.
// A grant covers a whole burst; each ACC result is tagged from an in-order FIFO of burst owners.
module acc_arbiter #(
  parameter int DataWidth               = 32,
  parameter int NumberOfRequesters      = 4,
  parameter int RequesterIdWidth        = 2,
  parameter int NumberOfAccumulate      = 4,
  parameter int NumberOfAccumulateWidth = 2,
  parameter int MaxOutstanding          = 4,
  parameter int MaxOutstandingWidth     = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NumberOfRequesters-1:0]            ReqValid,
  input  logic [NumberOfRequesters*DataWidth-1:0]  ReqData,
  output logic [NumberOfRequesters-1:0]            ReqGrant,
  output logic                                     AccInValid,
  output logic [DataWidth-1:0]                     AccIn,
  input  logic                                     AccOutValid,
  input  logic [DataWidth-1:0]                     AccOut,
  output logic                                     DataOutValid,
  output logic [DataWidth-1:0]                     DataOut,
  output logic [RequesterIdWidth-1:0]              DataOutId,
  output logic                                     Busy,
  output logic                                     Error
);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [MaxOutstandingWidth:0]       FifoDepth = (MaxOutstandingWidth+1)'(MaxOutstanding);
  localparam logic [NumberOfAccumulateWidth-1:0] LastBeat  = NumberOfAccumulateWidth'(NumberOfAccumulate-1);

  state_t                             r_state;
  logic [NumberOfRequesters-1:0]      r_grant;
  logic [RequesterIdWidth-1:0]        r_gnt_id;
  logic [RequesterIdWidth-1:0]        r_rr_ptr;
  logic [NumberOfAccumulateWidth-1:0] r_beat;
  logic                               r_acc_in_valid;
  logic [DataWidth-1:0]               r_acc_in;
  logic                               r_out_valid;
  logic [DataWidth-1:0]               r_out_data;
  logic [RequesterIdWidth-1:0]        r_out_id;
  logic                               r_error;
  logic [RequesterIdWidth-1:0]        r_fifo [MaxOutstanding];
  logic [MaxOutstandingWidth-1:0]     r_wr_ptr;
  logic [MaxOutstandingWidth-1:0]     r_rd_ptr;
  logic [MaxOutstandingWidth:0]       r_count;

  logic [RequesterIdWidth-1:0]        w_cand [NumberOfRequesters];
  logic                               w_found;
  logic [RequesterIdWidth-1:0]        w_winner;
  logic [DataWidth-1:0]               w_req_data;
  logic                               w_accept;
  logic                               w_last_beat;
  logic                               w_full;
  logic                               w_empty;
  logic                               w_push;
  logic                               w_pop;

  // Round-robin search: first valid requester starting just after the last burst owner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < NumberOfRequesters; i++) begin
      w_cand[i] = RequesterIdWidth'((int'(r_rr_ptr) + 1 + i) % NumberOfRequesters);
    end
    for (int i = 0; i < NumberOfRequesters; i++) begin
      if (!w_found && ReqValid[w_cand[i]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[i];
      end else begin
        w_found  = w_found;
        w_winner = w_winner;
      end
    end
  end

  assign w_req_data  = ReqData[r_gnt_id*DataWidth +: DataWidth];
  assign w_accept    = (r_state == BURST) & ReqValid[r_gnt_id] & r_grant[r_gnt_id];
  assign w_last_beat = (r_beat == LastBeat);
  // Full is judged on occupancy before any same-cycle pop, so a freed slot is seen one cycle late.
  assign w_full      = (r_count == FifoDepth);
  assign w_empty     = (r_count == '0);
  assign w_push      = (r_state == IDLE) & w_found & ~w_full;
  assign w_pop       = AccOutValid & ~w_empty;

  // Burst FSM: grant, beat forwarding and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_grant        <= '0;
      r_gnt_id       <= '0;
      r_rr_ptr       <= RequesterIdWidth'(NumberOfRequesters-1);
      r_beat         <= '0;
      r_acc_in_valid <= 1'b0;
      r_acc_in       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_acc_in_valid <= 1'b0;
          if (w_push) begin
            r_grant  <= NumberOfRequesters'(1) << w_winner;
            r_gnt_id <= w_winner;
            r_state  <= BURST;
          end
        end
        BURST: begin
          if (w_accept) begin
            r_acc_in_valid <= 1'b1;
            r_acc_in       <= w_req_data;
            if (w_last_beat) begin
              r_beat   <= '0;
              r_grant  <= '0;
              r_rr_ptr <= r_gnt_id;
              r_state  <= IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end else begin
            r_acc_in_valid <= 1'b0;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_grant        <= '0;
          r_beat         <= '0;
          r_acc_in_valid <= 1'b0;
        end
      endcase
    end
  end

  // Owner-ID FIFO and tagged result register; an unmatched result raises sticky Error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_out_valid <= AccOutValid;
      if (AccOutValid) begin
        r_out_data <= AccOut;
        if (w_empty) begin
          r_out_id <= '0;
          r_error  <= 1'b1;
        end else begin
          r_out_id <= r_fifo[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_winner;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ReqGrant     = r_grant;
  assign AccInValid   = r_acc_in_valid;
  assign AccIn        = r_acc_in;
  assign DataOutValid = r_out_valid;
  assign DataOut      = r_out_data;
  assign DataOutId    = r_out_id;
  assign Busy         = (r_state == BURST) | ~w_empty;
  assign Error        = r_error;

endmodule
